// File: rtl/cu_pkg.sv
// Shared encodings for the IDP control sequencer: op classes, FSM states,
// write-back source and destination selects, and fixed register numbers.
package cu_pkg;

  typedef enum logic [2:0] {
    CLS_ALU  = 3'd0,
    CLS_HILO = 3'd1,
    CLS_MFHI = 3'd2,
    CLS_MFLO = 3'd3,
    CLS_LOAD = 3'd4,
    CLS_LINK = 3'd5,
    CLS_CMP  = 3'd6,
    CLS_ILL  = 3'd7
  } op_class_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_EX    = 3'd2,
    ST_MEMW  = 3'd3,
    ST_WB    = 3'd4,
    ST_FAULT = 3'd5
  } state_t;

  // Y_Sel: source of the write-back bus
  localparam logic [2:0] YS_ALU = 3'b000;
  localparam logic [2:0] YS_HI  = 3'b001;
  localparam logic [2:0] YS_LO  = 3'b010;
  localparam logic [2:0] YS_DIN = 3'b011;
  localparam logic [2:0] YS_PC  = 3'b100;

  // DA_Sel: destination register address source
  localparam logic [1:0] DA_D  = 2'b00;
  localparam logic [1:0] DA_T  = 2'b01;
  localparam logic [1:0] DA_RA = 2'b10;
  localparam logic [1:0] DA_SP = 2'b11;

  localparam logic [4:0] REG_RA = 5'd31;
  localparam logic [4:0] REG_SP = 5'd29;

  // Default number of cycles a load may wait for memory data
  localparam int MEM_TIMEOUT_DEF = 15;

endpackage

// File: rtl/idp_sequencer_if.sv
// Decoded-operation handshake between the instruction decoder (master)
// and the IDP sequencer (slave).
interface idp_sequencer_if;
  logic       op_valid;
  logic       op_ready;
  logic [2:0] op_class;
  logic [4:0] op_fs;
  logic [4:0] op_s;
  logic [4:0] op_t;
  logic [4:0] op_d;
  logic       op_imm;
  logic       op_wt;

  modport master (
    output op_valid, op_class, op_fs, op_s, op_t, op_d, op_imm, op_wt,
    input  op_ready
  );

  modport slave (
    input  op_valid, op_class, op_fs, op_s, op_t, op_d, op_imm, op_wt,
    output op_ready
  );
endinterface

// File: rtl/idp_sequencer.sv
// Multi-cycle sequencer owning every IDP control input. One operation at a
// time is accepted in IDLE, latched, and walked through operand read,
// execute, memory wait and write-back. All selects/addresses come from the
// latched fields, so they stay stable for the whole operation.
module idp_sequencer
  import cu_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  idp_sequencer_if.slave   op,
  input  logic             mem_valid,
  input  logic             Z,
  input  logic             N,
  input  logic             C,
  input  logic             V,
  output logic             D_En,
  output logic             HILO_ld,
  output logic             T_Sel,
  output logic [1:0]       DA_Sel,
  output logic [2:0]       Y_Sel,
  output logic [4:0]       FS,
  output logic [4:0]       S_Addr,
  output logic [4:0]       T_Addr,
  output logic [4:0]       D_Addr,
  output logic [3:0]       flags_q,
  output logic             done,
  output logic             err
);

  localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_reg, state_next;
  op_class_t  cls_reg;
  logic [4:0] fs_reg, s_reg, t_reg, d_reg;
  logic       imm_reg, wt_reg;
  logic [7:0] cnt_reg;
  logic [3:0] flags_reg;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Latch the operation fields at the accept edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cls_reg <= CLS_ALU;
      fs_reg  <= '0;
      s_reg   <= '0;
      t_reg   <= '0;
      d_reg   <= '0;
      imm_reg <= 1'b0;
      wt_reg  <= 1'b0;
    end else if (state_reg == ST_IDLE && op.op_valid) begin
      cls_reg <= op_class_t'(op.op_class);
      fs_reg  <= op.op_fs;
      s_reg   <= op.op_s;
      t_reg   <= op.op_t;
      d_reg   <= op.op_d;
      imm_reg <= op.op_imm;
      wt_reg  <= op.op_wt;
    end
  end

  // Memory-wait counter: cleared outside MEMW, counts cycles spent waiting
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  cnt_reg <= '0;
    else if (state_reg == ST_MEMW) cnt_reg <= cnt_reg + 8'd1;
    else                         cnt_reg <= '0;
  end

  // Capture ALU flags at the close of an ALU or compare execute cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      flags_reg <= '0;
    else if (state_reg == ST_EX && (cls_reg == CLS_ALU || cls_reg == CLS_CMP))
      flags_reg <= {Z, N, C, V};
  end

  // Next-state and Moore-decoded strobes
  always_comb begin
    state_next  = state_reg;
    op.op_ready = 1'b0;
    D_En        = 1'b0;
    HILO_ld     = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        op.op_ready = 1'b1;
        if (op.op_valid) begin
          case (op_class_t'(op.op_class))
            CLS_ALU, CLS_HILO, CLS_CMP:   state_next = ST_RD;
            CLS_MFHI, CLS_MFLO, CLS_LINK: state_next = ST_WB;
            CLS_LOAD:                     state_next = ST_MEMW;
            default:                      state_next = ST_FAULT;
          endcase
        end
      end
      ST_RD: state_next = ST_EX;
      ST_EX: begin
        if (cls_reg == CLS_HILO) begin
          HILO_ld    = 1'b1;
          done       = 1'b1;
          state_next = ST_IDLE;
        end else if (cls_reg == CLS_CMP) begin
          done       = 1'b1;
          state_next = ST_IDLE;
        end else begin
          state_next = ST_WB;
        end
      end
      ST_MEMW: begin
        // data arriving on the timeout cycle still completes the load
        if (mem_valid)                 state_next = ST_WB;
        else if (cnt_reg == CNT_LAST)  state_next = ST_FAULT;
      end
      ST_WB: begin
        D_En       = 1'b1;
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      ST_FAULT: begin
        err        = 1'b1;
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Write-back source and destination selects from the latched class
  always_comb begin
    Y_Sel  = YS_ALU;
    DA_Sel = {1'b0, wt_reg};
    case (cls_reg)
      CLS_MFHI: Y_Sel = YS_HI;
      CLS_MFLO: Y_Sel = YS_LO;
      CLS_LOAD: Y_Sel = YS_DIN;
      CLS_LINK: begin
        Y_Sel  = YS_PC;
        DA_Sel = DA_RA;
      end
      default:  Y_Sel = YS_ALU;
    endcase
  end

  assign FS      = fs_reg;
  assign S_Addr  = s_reg;
  assign T_Addr  = t_reg;
  assign D_Addr  = d_reg;
  assign T_Sel   = imm_reg;
  assign flags_q = flags_reg;

endmodule

// File: tb/tb_idp_sequencer.sv
// Bench for idp_sequencer: a small behavioural IDP (register file, RS/RT,
// ALU, HI/LO, D_in) is driven by the sequencer's controls. A vector table
// gives each operation with its expected latency, flags and write-back;
// expected writes go into a queue and are popped when D_En is observed.
module tb_idp_sequencer;
  import cu_pkg::*;

  localparam logic [4:0]  FS_ADD = 5'h02;
  localparam logic [4:0]  FS_SUB = 5'h06;
  localparam logic [31:0] PC_IN  = 32'h0040_0100;
  localparam logic [31:0] DT     = 32'hFFFF_FFFF;
  localparam int          NVEC   = 13;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic mem_valid = 1'b0;
  logic Z, N, C, V;
  logic D_En, HILO_ld, T_Sel, done, err;
  logic [1:0] DA_Sel;
  logic [2:0] Y_Sel;
  logic [4:0] FS, S_Addr, T_Addr, D_Addr;
  logic [3:0] flags_q;
  logic [31:0] DY = '0;

  idp_sequencer_if opif();

  idp_sequencer #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .op(opif), .mem_valid(mem_valid),
    .Z(Z), .N(N), .C(C), .V(V),
    .D_En(D_En), .HILO_ld(HILO_ld), .T_Sel(T_Sel), .DA_Sel(DA_Sel),
    .Y_Sel(Y_Sel), .FS(FS), .S_Addr(S_Addr), .T_Addr(T_Addr),
    .D_Addr(D_Addr), .flags_q(flags_q), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural IDP model ----------------
  logic [31:0] regs [32];
  logic [31:0] rs_m, rt_m, alu_m, din_m, hi_m, lo_m;
  logic [32:0] sum;
  logic [31:0] y_m;
  logic [4:0]  wdest_m;
  logic        preload = 1'b1;

  always_comb begin
    sum = '0;
    V   = 1'b0;
    case (FS)
      FS_ADD: begin
        sum = {1'b0, rs_m} + {1'b0, rt_m};
        V   = (rs_m[31] == rt_m[31]) && (sum[31] != rs_m[31]);
      end
      FS_SUB: begin
        sum = {1'b0, rs_m} + {1'b0, ~rt_m} + 33'd1;
        V   = (rs_m[31] != rt_m[31]) && (sum[31] != rs_m[31]);
      end
      default: sum = {1'b0, rs_m & rt_m};
    endcase
    Z = (sum[31:0] == 32'd0);
    N = sum[31];
    C = sum[32];
  end

  always_comb begin
    case (DA_Sel)
      2'b00:   wdest_m = D_Addr;
      2'b01:   wdest_m = T_Addr;
      2'b10:   wdest_m = 5'd31;
      default: wdest_m = 5'd29;
    endcase
    case (Y_Sel)
      3'b000:  y_m = alu_m;
      3'b001:  y_m = hi_m;
      3'b010:  y_m = lo_m;
      3'b011:  y_m = din_m;
      3'b100:  y_m = PC_IN;
      default: y_m = 32'hBAD0_BAD0;
    endcase
  end

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      regs[1] <= 32'd5;
      regs[2] <= 32'd7;
      regs[5] <= 32'h8000_0000;
      regs[6] <= 32'd5;
      rs_m <= '0; rt_m <= '0; alu_m <= '0; din_m <= '0; hi_m <= '0; lo_m <= '0;
    end else begin
      rs_m  <= regs[S_Addr];
      rt_m  <= T_Sel ? DT : regs[T_Addr];
      alu_m <= sum[31:0];
      if (mem_valid) din_m <= DY;
      if (HILO_ld) {hi_m, lo_m} <= {32'd0, rs_m} * {32'd0, rt_m};
      if (D_En) regs[wdest_m] <= y_m;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [4:0]  dest;
    logic [31:0] data;
  } wr_t;
  wr_t wq[$];

  int checks = 0;
  int failures = 0;

  // pop an expected write whenever the sequencer enables a register write
  always @(negedge clk) begin
    if (reset && D_En) begin
      checks++;
      if (wq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write got dest=%0d data=%h, required no write", wdest_m, y_m);
      end else begin
        wr_t e;
        e = wq.pop_front();
        if (wdest_m !== e.dest || y_m !== e.data) begin
          failures++;
          $display("FAIL write got dest=%0d data=%h, required dest=%0d data=%h",
                   wdest_m, y_m, e.dest, e.data);
        end else
          $display("write dest=%0d data=%h ok", wdest_m, y_m);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0]  cls;
    logic [4:0]  fs, s, t, d;
    logic        imm, wt;
    int          mem_wait;   // MEMW cycles before mem_valid (255: never)
    logic [31:0] dy;
    int          lat;        // accept edge to done cycle
    logic        wr;
    logic [4:0]  wdest;
    logic [31:0] wdata;
    int          errs;
    logic        chk_flags;
    logic [3:0]  flags;
    int          hilo;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic run_op(input int idx, input vec_t v);
    int cyc, lat, errc, hc;
    @(negedge clk);
    opif.op_valid = 1'b1;
    opif.op_class = v.cls;
    opif.op_fs    = v.fs;
    opif.op_s     = v.s;
    opif.op_t     = v.t;
    opif.op_d     = v.d;
    opif.op_imm   = v.imm;
    opif.op_wt    = v.wt;
    DY            = v.dy;
    if (v.wr) wq.push_back('{dest: v.wdest, data: v.wdata});
    @(posedge clk); #1;
    opif.op_valid = 1'b0;
    cyc = 1; lat = -1; errc = 0; hc = 0;
    while (cyc <= 40) begin
      mem_valid = (v.cls == 3'd4) && (cyc == v.mem_wait + 1);
      @(negedge clk);
      if (err) errc++;
      if (HILO_ld) hc++;
      if (cyc == 1 && (v.cls == 3'd0 || v.cls == 3'd1 || v.cls == 3'd6))
        check("t_sel_rd", 64'(T_Sel), 64'(v.imm));
      if (done) begin
        lat = cyc;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    mem_valid = 1'b0;
    check("latency", 64'(lat), 64'(v.lat));
    check("err_cycles", 64'(errc), 64'(v.errs));
    check("hilo_cycles", 64'(hc), 64'(v.hilo));
    @(posedge clk); #1;
    check("op_ready_after", 64'(opif.op_ready), 64'd1);
    if (v.chk_flags) check("flags_q", 64'(flags_q), 64'(v.flags));
    check("missing_writes", 64'(wq.size()), 64'd0);
    wq.delete();
    $display("op %0d class=%0d latency=%0d err=%0d flags=%b", idx, v.cls, lat, errc, flags_q);
  endtask

  initial begin
    //           cls   fs      s     t      d     imm   wt   mw   dy              lat wr    wdest   wdata            errs chk   flags    hilo
    vecs[0]  = '{3'd0, FS_ADD, 5'd1, 5'd2,  5'd3, 1'b0, 1'b0, 255, 32'h0,          3, 1'b1, 5'd3,  32'd12,          0, 1'b1, 4'b0000, 0};
    vecs[1]  = '{3'd0, FS_ADD, 5'd1, 5'd4,  5'd0, 1'b1, 1'b1, 255, 32'h0,          3, 1'b1, 5'd4,  32'd4,           0, 1'b1, 4'b0010, 0};
    vecs[2]  = '{3'd1, 5'd0,   5'd5, 5'd6,  5'd0, 1'b0, 1'b0, 255, 32'h0,          2, 1'b0, 5'd0,  32'd0,           0, 1'b0, 4'b0000, 1};
    vecs[3]  = '{3'd2, 5'd0,   5'd0, 5'd0,  5'd7, 1'b0, 1'b0, 255, 32'h0,          1, 1'b1, 5'd7,  32'd2,           0, 1'b0, 4'b0000, 0};
    vecs[4]  = '{3'd3, 5'd0,   5'd0, 5'd0,  5'd8, 1'b0, 1'b0, 255, 32'h0,          1, 1'b1, 5'd8,  32'h8000_0000,   0, 1'b0, 4'b0000, 0};
    vecs[5]  = '{3'd4, 5'd0,   5'd0, 5'd0,  5'd9, 1'b0, 1'b0, 3,   32'hDA7A_0005,  5, 1'b1, 5'd9,  32'hDA7A_0005,   0, 1'b0, 4'b0000, 0};
    vecs[6]  = '{3'd4, 5'd0,   5'd0, 5'd10, 5'd1, 1'b0, 1'b1, 0,   32'hDA7A_0006,  2, 1'b1, 5'd10, 32'hDA7A_0006,   0, 1'b0, 4'b0000, 0};
    vecs[7]  = '{3'd4, 5'd0,   5'd0, 5'd0,  5'd11,1'b0, 1'b0, 255, 32'hDA7A_0007, 16, 1'b0, 5'd0,  32'd0,           1, 1'b0, 4'b0000, 0};
    vecs[8]  = '{3'd4, 5'd0,   5'd0, 5'd0,  5'd11,1'b0, 1'b0, 14,  32'hDA7A_0008, 16, 1'b1, 5'd11, 32'hDA7A_0008,   0, 1'b0, 4'b0000, 0};
    vecs[9]  = '{3'd5, 5'd0,   5'd0, 5'd2,  5'd2, 1'b0, 1'b1, 255, 32'h0,          1, 1'b1, 5'd31, PC_IN,           0, 1'b0, 4'b0000, 0};
    vecs[10] = '{3'd6, FS_SUB, 5'd1, 5'd2,  5'd0, 1'b0, 1'b0, 255, 32'h0,          2, 1'b0, 5'd0,  32'd0,           0, 1'b1, 4'b0100, 0};
    vecs[11] = '{3'd7, 5'd0,   5'd0, 5'd0,  5'd3, 1'b0, 1'b0, 255, 32'h0,          1, 1'b0, 5'd0,  32'd0,           1, 1'b0, 4'b0000, 0};
    vecs[12] = '{3'd0, FS_SUB, 5'd5, 5'd1,  5'd12,1'b0, 1'b0, 255, 32'h0,          3, 1'b1, 5'd12, 32'h7FFF_FFFB,   0, 1'b1, 4'b0011, 0};

    opif.op_valid = 1'b0; opif.op_class = '0; opif.op_fs = '0;
    opif.op_s = '0; opif.op_t = '0; opif.op_d = '0;
    opif.op_imm = 1'b0; opif.op_wt = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          64'({D_En, HILO_ld, T_Sel, done, err, DA_Sel, Y_Sel, FS, S_Addr, T_Addr, D_Addr, flags_q}),
          64'd0);
    check("reset_op_ready", 64'(opif.op_ready), 64'd1);
    preload = 1'b0;
    reset   = 1'b1;
    $display("reset released");

    for (int i = 0; i < NVEC; i++) run_op(i, vecs[i]);

    // reset asserted during EX of an ALU op: no write, flags cleared
    @(negedge clk);
    opif.op_valid = 1'b1; opif.op_class = 3'd0; opif.op_fs = FS_ADD;
    opif.op_s = 5'd1; opif.op_t = 5'd2; opif.op_d = 5'd13;
    opif.op_imm = 1'b0; opif.op_wt = 1'b0;
    @(posedge clk); #1;
    opif.op_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_flags", 64'(flags_q), 64'(4'b0011));
    reset = 1'b0;
    #1;
    check("abort_enables", 64'({D_En, HILO_ld, done, err}), 64'd0);
    check("abort_ready", 64'(opif.op_ready), 64'd1);
    check("abort_flags", 64'(flags_q), 64'd0);
    check("abort_selects", 64'({FS, D_Addr, DA_Sel, Y_Sel}), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_write", 64'(regs[13]), 64'd0);
    $display("reset abort sequence done");

    // recovery: a normal ALU op after the abort
    begin
      vec_t v;
      v = vecs[0];
      v.d = 5'd14;
      v.wdest = 5'd14;
      run_op(NVEC, v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // hard stop if the run ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/idp_sequencer.md
# idp_sequencer

Multi-cycle sequencer that drives the Integer Data Path's control inputs for one decoded operation at a time. Accepts an operation over a valid/ready handshake and walks it through operand read, execute and write-back phases, timed to the datapath's RS/RT/ALU_out/D_in scratch registers. Sits between the instruction decoder and the IDP and owns every IDP control input.

## Interface
- MEM_TIMEOUT, 15: maximum cycles to wait for `mem_valid` on a load (1..255).
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- op_valid  in  1  decoded operation present.
- op_ready  out  1  sequencer can accept; high only in IDLE.
- op_class  in  3  0 ALU, 1 HILO (mult/div), 2 MFHI, 3 MFLO, 4 LOAD, 5 LINK, 6 CMP, 7 illegal.
- op_fs  in  5  ALU function select.
- op_s, op_t, op_d  in  5 each  source S, source T, destination register.
- op_imm  in  1  use DT as the T operand.
- op_wt  in  1  write to T_Addr instead of D_Addr (I-type).
- mem_valid  in  1  DY valid this cycle.
- Z, N, C, V  in  1 each  ALU flags from the IDP.
- D_En, HILO_ld, T_Sel  out  1 each  IDP controls.
- DA_Sel  out  2  00 D_Addr, 01 T_Addr, 10 $ra, 11 $sp.
- Y_Sel  out  3  000 alu_out, 001 hi, 010 lo, 011 d_in, 100 pc_in.
- FS  out  5; S_Addr, T_Addr, D_Addr  out  5 each.
- flags_q  out  4  {Z,N,C,V} from the last ALU/CMP execute.
- done  out  1  high in the final cycle of an operation.
- err  out  1  one-cycle pulse on an illegal class or a load timeout.

## Operation
- States: IDLE, RD, EX, MEMW, WB, FAULT.
- IDLE: `op_ready`=1. On `op_valid`, latch all op fields into internal registers.
  - Class 0/1/6 go to RD. Class 2/3/5 go to WB. Class 4 goes to MEMW. Class 7 goes to FAULT.
- All IDP address and select outputs are driven from the latched fields and are stable for the whole operation.
- RD: drive S_Addr/T_Addr and set `T_Sel`=`op_imm`. RS/RT capture at the closing edge. Next state is EX.
- EX: drive FS. At the closing edge, ALU_out captures.
  - Class 1: `HILO_ld`=1, `done`=1, next state IDLE.
  - Class 6: `done`=1, next state IDLE, `flags_q` updates.
  - Class 0: next state WB, `flags_q` updates.
- MEMW: the counter starts at 0 and increments each cycle.
  - On `mem_valid`, go to WB; D_in captures at that edge.
  - If the counter reaches MEM_TIMEOUT-1 without `mem_valid`, go to FAULT.
  - If `mem_valid` arrives in the same cycle as the timeout, `mem_valid` wins.
- WB: `D_En`=1, `done`=1, next state IDLE.
  - Class 0: Y_Sel=000, DA_Sel={0,`op_wt`}.
  - Class 2: Y_Sel=001. Class 3: Y_Sel=010. Class 4: Y_Sel=011. For classes 2, 3 and 4, DA_Sel={0,`op_wt`}.
  - Class 5: Y_Sel=100, DA_Sel=10.
- FAULT: `err`=1, `done`=1, no `D_En`/`HILO_ld`, next state IDLE.
- `D_En` and `HILO_ld` are never asserted outside WB and EX respectively.

## Timing
- Reset (asynchronous, `reset`=0):
  - State goes to IDLE and the counter to 0.
  - `flags_q`=0. `D_En`, `HILO_ld`, `T_Sel`, `done`, `err`=0. `DA_Sel`, `Y_Sel`, `FS` and all addresses =0.
  - `op_ready`=1 once `reset` deasserts.
- Reset mid-operation aborts with no write. A write-back in progress is dropped if reset asserts before the edge.
- Latency from accept edge to the `done` cycle:
  - ALU: 3 cycles (RD, EX, WB).
  - HILO/CMP: 2 cycles.
  - MFHI/MFLO/LINK: 1 cycle.
  - LOAD: 1+k+1 cycles, where k = cycles until `mem_valid`.
- Back-to-back: the next op can be accepted the cycle after `done` (IDLE). There is no pipelining.
- Outputs are Moore-decoded from state and latched fields; no output depends combinationally on `op_valid`.

## Structure
- Shared package `cu_pkg`: op_class codes, state enum, Y_Sel and DA_Sel encodings, register constants RA=31 and SP=29.
- Single module; the MEMW counter is inline. No sub-module.

## Test plan
- ALU op: class 0, fs=ADD, s=1 (=5), t=2 (=7), d=3 → `D_En` in cycle 3 with DA_Sel=00, D_Addr=3; $3=12; `done` in cycle 3.
- Immediate with `op_wt`=1, t=4, DT=0xFFFF_FFFF, s=1 (=5), ADD → `T_Sel`=1 in RD; DA_Sel=01 in WB; $4=4; `flags_q` C=1.
- Mult: class 1 → `HILO_ld` exactly one cycle in EX, no `D_En`; following MFHI writes the hi value to d in 1 cycle.
- Load with `mem_valid` after 3 wait cycles → WB Y_Sel=011, `done` at cycle 5. With no `mem_valid` and MEM_TIMEOUT=15 → `err` pulse in FAULT, no write.
- LINK → DA_Sel=10, Y_Sel=100, $31=pc_in. Illegal class 7 → `err`=1 for one cycle, `op_ready` back the next cycle.
- Assert `reset` in EX of an ALU op → immediate IDLE, all enables 0, `flags_q`=0, no register written.
